// File: rtl/mm_wide_addsub.sv
// mm_wide_addsub: Avalon-MM wide add/subtract peripheral.
// Operands A and B (DATA_W bits) are loaded 32 bits at a time through a
// word-index register. A run ripples one 32-bit word per cycle, least
// significant word first, with the carry held between cycles.
// Optional feature: define MM_WIDE_ADDSUB_AUTOINC_EN so that the word index
// advances after each accepted A_DATA/B_DATA write and each SUM_DATA read.
//
// Bus handshake: read and write are single-cycle strobes with no waitrequest.
// A write is sampled on the rising edge where write=1. readdata is registered
// with a fixed read latency of 1 and returns the contents from before any
// write sampled on the same edge. It holds its value while read=0.
module mm_wide_addsub #(
    parameter int DATA_W = 128
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata
);

    localparam int NUM_WORDS = DATA_W / 32;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Current FSM state; kept as a named enum so checkers can bind to it.
    state_t state;
    state_t state_next;

    logic [31:0]      a_mem   [NUM_WORDS];
    logic [31:0]      b_mem   [NUM_WORDS];
    logic [31:0]      sum_mem [NUM_WORDS];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] k;
    logic             carry;
    logic             sub;
    logic             done;

    logic             busy;
    logic             wr_ctrl;
    logic             do_clear;
    logic             do_start;
    logic             wr_sel;
    logic             wr_a;
    logic             wr_b;
    logic             rd_sum;
    logic             last_word;
    logic             wipe;
    logic [32:0]      sum_word;
    logic [31:0]      rd_mux;

    assign busy      = (state == ST_RUN);
    assign wr_ctrl   = write && (address == 3'd0);
    // CLEAR wins over START when both are set in the same write.
    assign do_clear  = wr_ctrl && writedata[2];
    assign do_start  = wr_ctrl && writedata[0] && !writedata[2] && !busy;
    // Operand and index writes are locked out while a run is in flight.
    assign wr_sel    = write && (address == 3'd1) && !busy;
    assign wr_a      = write && (address == 3'd2) && !busy;
    assign wr_b      = write && (address == 3'd3) && !busy;
    assign rd_sum    = read && (address == 3'd4) && !busy;
    assign last_word = (k == IDX_W'(NUM_WORDS - 1));
    assign wipe      = !resetn || do_clear;

    // One ripple step: subtraction is A + ~B with the initial carry set to 1.
    assign sum_word = {1'b0, a_mem[k]} + {1'b0, (sub ? ~b_mem[k] : b_mem[k])} + {32'b0, carry};

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: START launches a run, last word ends it, CLEAR aborts.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (do_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_word) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (do_clear) begin
            state_next = ST_IDLE;
        end
    end

    // Operand storage, ripple datapath, index and status flags.
    always_ff @(posedge clock) begin
        if (wipe) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                a_mem[i]   <= '0;
                b_mem[i]   <= '0;
                sum_mem[i] <= '0;
            end
            idx   <= '0;
            k     <= '0;
            carry <= 1'b0;
            sub   <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (do_start) begin
                k     <= '0;
                carry <= writedata[1];
                sub   <= writedata[1];
                done  <= 1'b0;
            end
            if (busy) begin
                sum_mem[k] <= sum_word[31:0];
                carry      <= sum_word[32];
                k          <= k + IDX_W'(1);
                if (last_word) begin
                    done <= 1'b1;
                end
            end
            if (wr_a) begin
                a_mem[idx] <= writedata;
            end
            if (wr_b) begin
                b_mem[idx] <= writedata;
            end
            if (wr_sel) begin
                idx <= writedata[IDX_W-1:0];
            end
`ifdef MM_WIDE_ADDSUB_AUTOINC_EN
            if (wr_a || wr_b || rd_sum) begin
                idx <= idx + IDX_W'(1);
            end
`else
            if (rd_sum && 1'b0) begin
                idx <= idx;
            end
`endif
        end
    end

    // Read multiplexer over the register map.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: begin
                rd_mux[0]          = busy;
                rd_mux[1]          = done;
                rd_mux[2]          = carry;
                rd_mux[3]          = sub;
                rd_mux[IDX_W+7:8]  = idx;
            end
            3'd1:    rd_mux = {{(32 - IDX_W){1'b0}}, idx};
            3'd2:    rd_mux = a_mem[idx];
            3'd3:    rd_mux = b_mem[idx];
            3'd4:    rd_mux = sum_mem[idx];
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, held while read is low.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_mm_wide_addsub.sv
// tb_mm_wide_addsub: directed and randomized checks of mm_wide_addsub
// against a wide-integer reference model.
module tb_mm_wide_addsub;

    localparam int DATA_W    = 128;
    localparam int NUM_WORDS = DATA_W / 32;
    localparam int IDX_W     = 2;
`ifdef MM_WIDE_ADDSUB_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clock;
    logic        resetn;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    int checks;
    int errors;
    logic [IDX_W-1:0] m_idx;
    logic [31:0] rd;

    mm_wide_addsub #(.DATA_W(DATA_W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input logic busy, input logic done,
                                                input logic carry, input logic sub,
                                                input logic [IDX_W-1:0] idx);
        logic [31:0] s;
        s = '0;
        s[0] = busy;
        s[1] = done;
        s[2] = carry;
        s[3] = sub;
        s[IDX_W+7:8] = idx;
        return s;
    endfunction

    // Driver tasks: called at a falling edge, return at the next falling edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic sel(input int w);
        bus_write(3'd1, 32'(w));
        m_idx = IDX_W'(w);
    endtask

    task automatic load(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        for (int w = 0; w < NUM_WORDS; w++) begin
            sel(w);
            bus_write(3'd2, a[w*32 +: 32]);
            if (AUTOINC) m_idx++;
            sel(w);
            bus_write(3'd3, b[w*32 +: 32]);
            if (AUTOINC) m_idx++;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            bus_read(3'd0, rd);
            n++;
        end while (rd[0] && n < 20);
        check("wait_done busy", {31'b0, rd[0]}, 32'd0);
    endtask

    // Reference model: plain wide-integer arithmetic, then status and SUM words.
    task automatic check_result(input string tag, input logic [DATA_W-1:0] a,
                                input logic [DATA_W-1:0] b, input logic sub);
        logic [DATA_W:0] full;
        logic [DATA_W-1:0] exp_sum;
        logic exp_carry;
        logic [31:0] exp_q[$];
        if (sub) begin
            exp_sum = a - b;
            exp_carry = (a >= b);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            exp_sum = full[DATA_W-1:0];
            exp_carry = full[DATA_W];
        end
        for (int w = 0; w < NUM_WORDS; w++) exp_q.push_back(exp_sum[w*32 +: 32]);
        bus_read(3'd0, rd);
        check({tag, " status"}, rd, status_word(1'b0, 1'b1, exp_carry, sub, m_idx));
        for (int w = 0; w < NUM_WORDS; w++) begin
            sel(w);
            bus_read(3'd4, rd);
            if (AUTOINC) m_idx++;
            check($sformatf("%s sum[%0d]", tag, w), rd, exp_q.pop_front());
        end
    endtask

    task automatic check_cleared(input string tag);
        bus_read(3'd0, rd);
        check({tag, " status"}, rd, 32'd0);
        for (int w = 0; w < NUM_WORDS; w++) begin
            sel(w);
            bus_read(3'd4, rd);
            if (AUTOINC) m_idx++;
            check($sformatf("%s sum[%0d]", tag, w), rd, 32'd0);
        end
        sel(0);
        bus_read(3'd2, rd);
        check({tag, " a[0]"}, rd, 32'd0);
    endtask

    logic [DATA_W-1:0] ta, tb;
    logic              tsub;
    logic [IDX_W-1:0]  saved_idx;

    initial begin
        checks = 0;
        errors = 0;
        m_idx = '0;
        resetn = 1'b0;
        address = '0;
        write = 1'b0;
        writedata = '0;
        read = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        // Reset state: every address reads 0.
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            check($sformatf("reset addr%0d", i), rd, 32'd0);
        end

        // Add with carry across three words; exact latency checked.
        ta = {32'h0, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF};
        tb = 128'd1;
        load(ta, tb);
        bus_write(3'd0, 32'h1);
        for (int i = 0; i < NUM_WORDS; i++) begin
            bus_read(3'd0, rd);
            check($sformatf("latency busy%0d", i), {30'b0, rd[1:0]}, 32'h1);
        end
        check_result("add_carry_chain", ta, tb, 1'b0);

        // SUM_DATA writes ignored, unused addresses read 0.
        sel(3);
        bus_write(3'd4, 32'hDEAD_BEEF);
        bus_read(3'd4, rd);
        if (AUTOINC) m_idx++;
        check("sum write ignored", rd, 32'h1);
        bus_read(3'd6, rd);
        check("addr6 zero", rd, 32'd0);

        // Add overflowing all words.
        ta = '1;
        tb = 128'd1;
        load(ta, tb);
        bus_write(3'd0, 32'h1);
        wait_done();
        check_result("add_overflow", ta, tb, 1'b0);

        // Subtract with borrow.
        ta = 128'd5;
        tb = 128'd7;
        load(ta, tb);
        bus_write(3'd0, 32'h3);
        wait_done();
        check_result("sub_borrow", ta, tb, 1'b1);

        // Randomized runs; first one subtracts equal operands.
        for (int r = 0; r < 6; r++) begin
            ta = {$urandom, $urandom, $urandom, $urandom};
            tb = {$urandom, $urandom, $urandom, $urandom};
            tsub = 1'($urandom_range(0, 1));
            if (r == 0) begin
                tb = ta;
                tsub = 1'b1;
            end
            load(ta, tb);
            bus_write(3'd0, {30'b0, tsub, 1'b1});
            wait_done();
            check_result($sformatf("rand%0d", r), ta, tb, tsub);
        end

        // Busy protection: operand write and second START during a run.
        ta = {$urandom, $urandom, $urandom, $urandom};
        tb = {$urandom, $urandom, $urandom, $urandom};
        load(ta, tb);
        saved_idx = m_idx;
        bus_write(3'd0, 32'h1);
        bus_write(3'd2, 32'h1234);
        bus_write(3'd0, 32'h3);
        wait_done();
        check_result("busy_protect", ta, tb, 1'b0);
        sel(int'(saved_idx));
        bus_read(3'd2, rd);
        check("busy a unchanged", rd, ta[int'(saved_idx)*32 +: 32]);

        // CLEAR (with START in the same write) two edges into a run.
        load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        bus_write(3'd0, 32'h1);
        @(negedge clock);
        bus_write(3'd0, 32'h5);
        m_idx = '0;
        check_cleared("clear_midrun");
        repeat (6) @(negedge clock);
        bus_read(3'd0, rd);
        check("clear no restart", rd, 32'd0);

        // Reset in the middle of a run.
        load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        bus_read(3'd6, rd);
        bus_write(3'd0, 32'h1);
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        m_idx = '0;
        check_cleared("reset_midrun");

        // Sequential A_DATA writes from idx 0.
        sel(0);
        bus_write(3'd2, 32'h11);
        bus_write(3'd2, 32'h22);
        bus_write(3'd2, 32'h33);
        bus_write(3'd2, 32'h44);
        bus_read(3'd1, rd);
        check("seq idx", rd, 32'd0);
        for (int w = 0; w < NUM_WORDS; w++) begin
            sel(w);
            bus_read(3'd2, rd);
            if (AUTOINC) check($sformatf("seq a[%0d]", w), rd, 32'h11 * (w + 1));
            else check($sformatf("seq a[%0d]", w), rd, (w == 0) ? 32'h44 : 32'h0);
        end

        // Read and write of A_DATA in the same cycle returns pre-write data.
        sel(1);
        address = 3'd2;
        writedata = 32'h55;
        write = 1'b1;
        read = 1'b1;
        @(negedge clock);
        write = 1'b0;
        read = 1'b0;
        check("rw old value", readdata, AUTOINC ? 32'h22 : 32'h0);
        sel(1);
        bus_read(3'd2, rd);
        check("rw new value", rd, 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
